// File: rtl/fifo_sc.sv
// First-word-fall-through FIFO on a single-clock RAM with a 1-cycle read.
// A 2-entry output buffer hides the RAM read latency from the consumer.

module ram_sc #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Matching addresses forward the write port, whether or not wr_en is set.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (wr_addr == rd_addr)
            rd_data <= wr_data;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

module fifo_sc #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 16
) (
    input  logic                         clock,
    input  logic                         n_rst,
    input  logic [WORD_SIZE-1:0]         i_data,
    input  logic                         i_valid,
    output logic                         i_ready,
    output logic [WORD_SIZE-1:0]         o_data,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [$clog2(DEPTH+3)-1:0]   count
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RCW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(DEPTH + 3);

    logic                 run;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_addr;
    logic [RCW-1:0]       ram_cnt;
    logic                 inflight;
    logic [1:0]           buf_cnt;
    logic [WORD_SIZE-1:0] buf0;
    logic [WORD_SIZE-1:0] buf1;
    logic [WORD_SIZE-1:0] rd_data;
    logic [2:0]           buf_occ;
    logic                 push;
    logic                 pop;
    logic                 fetch;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign i_ready = run && (ram_cnt != RCW'(DEPTH));
    assign o_valid = (buf_cnt != 2'd0);
    assign o_data  = buf0;
    assign push    = i_valid && i_ready;
    assign pop     = o_valid && o_ready;
    assign buf_occ = {1'b0, buf_cnt} + {2'b00, inflight};
    assign fetch   = (ram_cnt != '0) && (buf_occ < (3'd2 + {2'b00, pop}));
    assign count   = CW'(ram_cnt) + CW'(inflight) + CW'(buf_cnt);

    // An idle write port is parked off the read address so no stale data is forwarded.
    assign wr_addr = push ? wr_ptr : (rd_ptr ^ AW'(1));

    ram_sc #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_addr),
        .wr_data (i_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            run      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            run      <= 1'b1;
            inflight <= fetch;
            buf_cnt  <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (fetch)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !fetch)
                ram_cnt <= ram_cnt + RCW'(1);
            else if (!push && fetch)
                ram_cnt <= ram_cnt - RCW'(1);
        end
    end

    // Output buffer: buf0 is the head; an arriving read fills the first free slot.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            if (inflight && !pop) begin
                if (buf_cnt == 2'd0)
                    buf0 <= rd_data;
                else
                    buf1 <= rd_data;
            end else if (!inflight && pop) begin
                if (buf_cnt == 2'd2)
                    buf0 <= buf1;
            end else if (inflight && pop) begin
                if (buf_cnt == 2'd1) begin
                    buf0 <= rd_data;
                end else begin
                    buf0 <= buf1;
                    buf1 <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_sc.sv
// Directed bench for fifo_sc: a DEPTH=16 instance for fill/drain/reset
// cases and a DEPTH=5 instance for long streaming across pointer wrap.

module tb_fifo_sc;

    logic       clock = 1'b0;
    logic       n_rst = 1'b1;

    logic [7:0] i_data  = 8'h00;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ready = 1'b0;
    logic [4:0] count;

    logic [7:0] i_data_b  = 8'h00;
    logic       i_valid_b = 1'b0;
    logic       i_ready_b;
    logic [7:0] o_data_b;
    logic       o_valid_b;
    logic       o_ready_b = 1'b0;
    logic [2:0] count_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    fifo_sc #(.WORD_SIZE(8), .DEPTH(16)) dut (
        .clock   (clock),
        .n_rst   (n_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .count   (count)
    );

    fifo_sc #(.WORD_SIZE(8), .DEPTH(5)) dut_b (
        .clock   (clock),
        .n_rst   (n_rst),
        .i_data  (i_data_b),
        .i_valid (i_valid_b),
        .i_ready (i_ready_b),
        .o_data  (o_data_b),
        .o_valid (o_valid_b),
        .o_ready (o_ready_b),
        .count   (count_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] stream_word(input int k);
        return 8'((k * 37 + 11) & 8'hFF);
    endfunction

    initial begin
        // Reset then idle
        #1 n_rst = 1'b0;
        #2;
        chk("rst_ovalid", 32'(o_valid), 32'd0);
        chk("rst_count",  32'(count),   32'd0);
        chk("rst_iready", 32'(i_ready), 32'd0);
        chk("rst_odata",  32'(o_data),  32'h00);
        repeat (3) @(posedge clock);
        #1 n_rst = 1'b1;
        tick();
        chk("rel_iready", 32'(i_ready), 32'd1);
        chk("rel_count",  32'(count),   32'd0);

        // Single word: accepted at edge t, visible after edge t+2
        i_data = 8'hA5; i_valid = 1'b1; o_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("sw_t0_ovalid", 32'(o_valid), 32'd0);
        chk("sw_t0_count",  32'(count),   32'd1);
        tick();
        chk("sw_t1_ovalid", 32'(o_valid), 32'd0);
        chk("sw_t1_count",  32'(count),   32'd1);
        tick();
        chk("sw_t2_ovalid", 32'(o_valid), 32'd1);
        chk("sw_t2_odata",  32'(o_data),  32'hA5);
        chk("sw_t2_count",  32'(count),   32'd1);
        tick();
        chk("sw_t3_ovalid", 32'(o_valid), 32'd0);
        chk("sw_t3_count",  32'(count),   32'd0);
        chk("sw_t3_odata",  32'(o_data),  32'hA5);

        // Fill with consumer stalled: 16 in RAM + 2 in buffer
        o_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            i_data = 8'(k); i_valid = 1'b1;
            chk($sformatf("fill_iready_%0d", k), 32'(i_ready), (k < 18) ? 32'd1 : 32'd0);
            tick();
        end
        // Full, with write data toggling on a refused push
        for (int h = 0; h < 4; h++) begin
            i_data = h[0] ? 8'h00 : 8'hFF;
            chk("full_iready", 32'(i_ready), 32'd0);
            tick();
        end
        chk("full_count",  32'(count),   32'd18);
        chk("full_ovalid", 32'(o_valid), 32'd1);
        chk("full_odata",  32'(o_data),  32'h00);
        i_valid = 1'b0; o_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("drain_ovalid_%0d", k), 32'(o_valid), 32'd1);
            chk($sformatf("drain_odata_%0d", k),  32'(o_data),  32'(k));
            tick();
            if (k == 0)
                chk("drain_iready", 32'(i_ready), 32'd1);
        end
        chk("drain_ovalid_end", 32'(o_valid), 32'd0);
        chk("drain_count_end",  32'(count),   32'd0);
        tick();
        tick();
        chk("empty_pop_count",  32'(count),   32'd0);
        chk("empty_pop_ovalid", 32'(o_valid), 32'd0);
        o_ready = 1'b0;

        // Streaming on DEPTH=5: one in RAM, one in flight, one in buffer
        i_valid_b = 1'b1; o_ready_b = 1'b1; i_data_b = stream_word(0);
        for (int j = 0; j < 102; j++) begin
            if (j < 99)
                chk("strm_iready", 32'(i_ready_b), 32'd1);
            tick();
            if (j < 99)
                i_data_b = stream_word(j + 1);
            else
                i_valid_b = 1'b0;
            if (j < 2) begin
                chk("strm_prime_ovalid", 32'(o_valid_b), 32'd0);
            end else begin
                chk($sformatf("strm_ovalid_%0d", j), 32'(o_valid_b), 32'd1);
                chk($sformatf("strm_odata_%0d", j),  32'(o_data_b),  32'(stream_word(j - 2)));
                if (j <= 99)
                    chk("strm_count", 32'(count_b), 32'd3);
            end
        end
        tick();
        chk("strm_end_ovalid", 32'(o_valid_b), 32'd0);
        chk("strm_end_count",  32'(count_b),   32'd0);
        o_ready_b = 1'b0;

        // Reset mid-operation with 7 words held
        for (int k = 0; k < 7; k++) begin
            i_data = 8'h10 + 8'(k); i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        tick();
        tick();
        chk("mid_count_pre", 32'(count), 32'd7);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_ovalid", 32'(o_valid), 32'd0);
        chk("mid_rst_count",  32'(count),   32'd0);
        chk("mid_rst_iready", 32'(i_ready), 32'd0);
        repeat (2) @(posedge clock);
        #1 n_rst = 1'b1;
        tick();
        chk("mid_rel_iready", 32'(i_ready), 32'd1);
        i_data = 8'h3C; i_valid = 1'b1; o_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("mid_first_ovalid_early", 32'(o_valid), 32'd0);
        tick();
        chk("mid_first_ovalid", 32'(o_valid), 32'd1);
        chk("mid_first_odata",  32'(o_data),  32'h3C);
        tick();
        chk("mid_after_count",  32'(count),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
